// File: rtl/exec_seq_pkg.sv
// Shared definitions for the exec_seq instruction sequencer.
//
// Holds the sequencer state enumeration, the two instruction encodings the
// sequencer recognises (EBREAK to stop, NOP as the reset instruction) and
// the fixed PC step between consecutive instructions.

package exec_seq_pkg;

   // The sequencer walks FETCH -> EXEC -> WB per instruction.
   // HALT and ERR are sticky until reset.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_HALT  = 3'd4,
      S_ERR   = 3'd5
   } state_e;

   // EBREAK stops the sequencer without being retired.
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   // addi x0,x0,0 is presented to the decoder after reset.
   localparam logic [31:0] NOP_INST    = 32'h0000_0013;

   // Fixed-length 32-bit instructions, so the PC always steps by four bytes.
   localparam logic [63:0] PC_INC      = 64'd4;

endpackage

// File: rtl/exec_seq.sv
// exec_seq: multi-cycle instruction sequencer (FETCH -> EXEC -> WB).
//
// Parameters
//   RESET_PC       PC value loaded on reset
//   FETCH_TIMEOUT  FETCH cycles without imem_rvalid before entering ERR
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        pulse that leaves IDLE and begins fetching
//   imem_req     fetch request, high throughout FETCH
//   imem_addr    fetch address (current PC)
//   imem_rvalid  fetch data valid, only honoured in FETCH
//   imem_rdata   fetched instruction
//   inst_o       latched instruction for decoder / regfile / immediates
//   dec_wen      register write enable coming back from the decoder
//   rf_wen       gated register-file write enable, only in WB
//   pc_o         current PC
//   busy         high in FETCH, EXEC or WB
//   halt         high once an EBREAK was fetched
//   err          high once a fetch timed out
//   retire_cnt   retired instruction count
//
// Configuration macro
//   EXEC_SEQ_PERF_EN  when defined, retire_cnt counts WB cycles; otherwise
//                     it is tied to zero and no counter register exists.

module exec_seq
   import exec_seq_pkg::*;
#(
   parameter logic [63:0] RESET_PC      = 64'h8000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_o,
   input  logic        dec_wen,
   output logic        rf_wen,
   output logic [63:0] pc_o,
   output logic        busy,
   output logic        halt,
   output logic        err,
   output logic [63:0] retire_cnt
);

   // Wide enough to hold FETCH_TIMEOUT itself, so the increment on the
   // final waiting cycle never overflows.
   localparam int WaitW = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(FETCH_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [WaitW-1:0] wait_q, wait_d;

   // Next-state and output decode. The wait counter is cleared whenever
   // FETCH is entered, so every fetch gets the full timeout budget. A
   // response arriving on the last allowed cycle wins over the timeout
   // because the rvalid branch is tested first. All outputs are forced low
   // while rst is high, which also keeps a WB cycle that coincides with
   // reset from writing the register file.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      wait_d   = wait_q;
      imem_req = 1'b0;
      rf_wen   = 1'b0;
      busy     = 1'b0;
      halt     = 1'b0;
      err      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            imem_req = 1'b1;
            busy     = 1'b1;
            if (imem_rvalid) begin
               inst_d  = imem_rdata;
               state_d = (imem_rdata == EBREAK_INST) ? S_HALT : S_EXEC;
            end else begin
               wait_d = wait_q + WaitW'(1);
               if (wait_q == WaitLast) begin
                  state_d = S_ERR;
               end
            end
         end
         S_EXEC: begin
            busy    = 1'b1;
            state_d = S_WB;
         end
         S_WB: begin
            busy    = 1'b1;
            rf_wen  = dec_wen;
            pc_d    = pc_q + PC_INC;
            wait_d  = '0;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rst) begin
         imem_req = 1'b0;
         rf_wen   = 1'b0;
         busy     = 1'b0;
         halt     = 1'b0;
         err      = 1'b0;
      end
   end

   // State, PC, instruction latch and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         wait_q  <= wait_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc_o      = pc_q;
   assign inst_o    = inst_q;

`ifdef EXEC_SEQ_PERF_EN
   logic [63:0] retire_q;

   // Every WB cycle retires exactly one instruction; EBREAK never reaches
   // WB so it is not counted. The counter wraps naturally at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_q <= '0;
      end else if (state_q == S_WB) begin
         retire_q <= retire_q + 64'd1;
      end
   end

   assign retire_cnt = retire_q;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_seq.sv
// Directed testbench for exec_seq.
//
// Two instances share all inputs: dut uses the default RESET_PC and u_wrap
// starts just below 2^64 to exercise PC wrap-around. Inputs change on the
// falling edge and outputs are sampled there too, away from the rising edge.

module tb_exec_seq;

   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] SW     = 32'h0020_a023;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dec_wen;

   logic        imem_req, rf_wen, busy, halt, err;
   logic [63:0] imem_addr, pc_o, retire_cnt;
   logic [31:0] inst_o;

   logic        wImemReq, wRfWen, wBusy, wHalt, wErr;
   logic [63:0] wImemAddr, wPc, wRetire;
   logic [31:0] wInst;

   int nCompared   = 0;
   int nMismatched = 0;
   logic [63:0] expRetire;

   exec_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_o(inst_o), .dec_wen(dec_wen), .rf_wen(rf_wen),
      .pc_o(pc_o), .busy(busy), .halt(halt), .err(err),
      .retire_cnt(retire_cnt)
   );

   exec_seq #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(wImemReq), .imem_addr(wImemAddr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_o(wInst), .dec_wen(dec_wen), .rf_wen(wRfWen),
      .pc_o(wPc), .busy(wBusy), .halt(wHalt), .err(wErr),
      .retire_cnt(wRetire)
   );

   always #5 clk = ~clk;

   // Hold reset for two edges, release it, and leave the bench sitting at a
   // falling edge with both instances idle.
   task automatic applyReset();
      rst = 1'b1; start = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_wen = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Pulse start for one cycle; returns at the first FETCH falling edge.
   task automatic applyStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // From a FETCH falling edge, deliver one instruction with zero wait and
   // report what the sequencer showed in FETCH, EXEC and WB. Returns at the
   // falling edge of the following FETCH.
   task automatic applyStimulus(input logic [31:0] inst, input logic wen,
                                output logic reqF, output logic [63:0] addrF,
                                output logic wenE, output logic wenW);
      reqF  = imem_req;
      addrF = imem_addr;
      imem_rvalid = 1'b1; imem_rdata = inst; dec_wen = wen;
      @(negedge clk);
      imem_rvalid = 1'b0;
      wenE = rf_wen;
      @(negedge clk);
      wenW = rf_wen;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_wen = 1'b1;
      @(negedge clk);
      @(negedge clk);
      nCompared++; if ({imem_req, rf_wen, busy, halt, err} !== 5'b0) begin nMismatched++; $display("[TB] FAIL rst_flags: got %b expected %b", {imem_req, rf_wen, busy, halt, err}, 5'b0); end
      nCompared++; if (pc_o !== 64'h8000_0000) begin nMismatched++; $display("[TB] FAIL rst_pc: got %h expected %h", pc_o, 64'h8000_0000); end
      nCompared++; if (inst_o !== NOP) begin nMismatched++; $display("[TB] FAIL rst_inst: got %h expected %h", inst_o, NOP); end
      nCompared++; if (retire_cnt !== 64'd0) begin nMismatched++; $display("[TB] FAIL rst_retire: got %0d expected 0", retire_cnt); end
      rst = 1'b0; dec_wen = 1'b0;
      @(negedge clk);
      nCompared++; if ({imem_req, rf_wen, busy, halt, err} !== 5'b0) begin nMismatched++; $display("[TB] FAIL post_rst_flags: got %b expected %b", {imem_req, rf_wen, busy, halt, err}, 5'b0); end
   endtask

   task automatic test_idle_ignore();
      imem_rvalid = 1'b1; imem_rdata = ADDI;
      @(negedge clk);
      @(negedge clk);
      imem_rvalid = 1'b0;
      nCompared++; if (inst_o !== NOP) begin nMismatched++; $display("[TB] FAIL idle_inst: got %h expected %h", inst_o, NOP); end
      nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_addi();
      logic reqF, wenE, wenW;
      logic [63:0] addrF;
      applyReset();
      applyStart();
      applyStimulus(ADDI, 1'b1, reqF, addrF, wenE, wenW);
      nCompared++; if (reqF !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_req: got %b expected 1", reqF); end
      nCompared++; if (addrF !== 64'h8000_0000) begin nMismatched++; $display("[TB] FAIL addi_addr: got %h expected %h", addrF, 64'h8000_0000); end
      nCompared++; if (wenE !== 1'b0) begin nMismatched++; $display("[TB] FAIL addi_exec_wen: got %b expected 0", wenE); end
      nCompared++; if (wenW !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_wb_wen: got %b expected 1", wenW); end
      nCompared++; if (imem_addr !== 64'h8000_0004) begin nMismatched++; $display("[TB] FAIL addi_next_addr: got %h expected %h", imem_addr, 64'h8000_0004); end
      nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL addi_next_req: got %b expected 1", imem_req); end
      nCompared++; if (rf_wen !== 1'b0) begin nMismatched++; $display("[TB] FAIL fetch_wen: got %b expected 0", rf_wen); end
   endtask

   // Continues from test_addi: a store-like instruction at 0x8000_0004.
   task automatic test_store();
      logic reqF, wenE, wenW;
      logic [63:0] addrF;
      applyStimulus(SW, 1'b0, reqF, addrF, wenE, wenW);
      nCompared++; if (addrF !== 64'h8000_0004) begin nMismatched++; $display("[TB] FAIL store_addr: got %h expected %h", addrF, 64'h8000_0004); end
      nCompared++; if ({wenE, wenW} !== 2'b00) begin nMismatched++; $display("[TB] FAIL store_wen: got %b expected 00", {wenE, wenW}); end
      nCompared++; if (pc_o !== 64'h8000_0008) begin nMismatched++; $display("[TB] FAIL store_pc: got %h expected %h", pc_o, 64'h8000_0008); end
   endtask

   task automatic test_back_to_back_halt();
      logic reqF, wenE, wenW;
      logic [63:0] addrF;
      applyReset();
      applyStart();
      applyStimulus(ADDI, 1'b1, reqF, addrF, wenE, wenW);
      applyStimulus(ADDI, 1'b1, reqF, addrF, wenE, wenW);
      nCompared++; if ({reqF, addrF} !== {1'b1, 64'h8000_0004}) begin nMismatched++; $display("[TB] FAIL b2b_second_fetch: got %b/%h expected 1/%h", reqF, addrF, 64'h8000_0004); end
      nCompared++; if (imem_addr !== 64'h8000_0008) begin nMismatched++; $display("[TB] FAIL b2b_third_addr: got %h expected %h", imem_addr, 64'h8000_0008); end
      imem_rvalid = 1'b1; imem_rdata = EBREAK;
      @(negedge clk);
      imem_rvalid = 1'b0;
      nCompared++; if ({halt, busy, imem_req, err} !== 4'b1000) begin nMismatched++; $display("[TB] FAIL halt_flags: got %b expected 1000", {halt, busy, imem_req, err}); end
      nCompared++; if (pc_o !== 64'h8000_0008) begin nMismatched++; $display("[TB] FAIL halt_pc: got %h expected %h", pc_o, 64'h8000_0008); end
`ifdef EXEC_SEQ_PERF_EN
      expRetire = 64'd2;
`else
      expRetire = 64'd0;
`endif
      nCompared++; if (retire_cnt !== expRetire) begin nMismatched++; $display("[TB] FAIL halt_retire: got %0d expected %0d", retire_cnt, expRetire); end
      start = 1'b1; imem_rvalid = 1'b1; imem_rdata = ADDI;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0; imem_rvalid = 1'b0;
      nCompared++; if ({halt, busy} !== 2'b10) begin nMismatched++; $display("[TB] FAIL halt_sticky: got %b expected 10", {halt, busy}); end
   endtask

   task automatic test_timeout_ok();
      logic anyErr;
      applyReset();
      applyStart();
      anyErr = 1'b0;
      for (int i = 0; i < 15; i++) begin
         anyErr = anyErr | err | ~imem_req;
         @(negedge clk);
      end
      imem_rvalid = 1'b1; imem_rdata = ADDI;
      @(negedge clk);
      imem_rvalid = 1'b0;
      nCompared++; if (anyErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_ok_wait: got %b expected 0", anyErr); end
      nCompared++; if ({err, busy, imem_req} !== 3'b010) begin nMismatched++; $display("[TB] FAIL to_ok_accept: got %b expected 010", {err, busy, imem_req}); end
      nCompared++; if (inst_o !== ADDI) begin nMismatched++; $display("[TB] FAIL to_ok_inst: got %h expected %h", inst_o, ADDI); end
   endtask

   task automatic test_timeout_err();
      logic anyErr;
      applyReset();
      applyStart();
      anyErr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         anyErr = anyErr | err | ~imem_req;
         @(negedge clk);
      end
      nCompared++; if (anyErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL to_err_wait: got %b expected 0", anyErr); end
      nCompared++; if ({err, imem_req, busy} !== 3'b100) begin nMismatched++; $display("[TB] FAIL to_err_flags: got %b expected 100", {err, imem_req, busy}); end
      imem_rvalid = 1'b1; imem_rdata = ADDI;
      @(negedge clk);
      imem_rvalid = 1'b0;
      nCompared++; if ({err, inst_o} !== {1'b1, NOP}) begin nMismatched++; $display("[TB] FAIL to_err_sticky: got %b/%h expected 1/%h", err, inst_o, NOP); end
   endtask

   task automatic test_reset_in_wb();
      applyReset();
      applyStart();
      imem_rvalid = 1'b1; imem_rdata = ADDI; dec_wen = 1'b1;
      @(negedge clk);
      imem_rvalid = 1'b0;
      @(negedge clk);
      nCompared++; if (rf_wen !== 1'b1) begin nMismatched++; $display("[TB] FAIL wb_wen_before_rst: got %b expected 1", rf_wen); end
      rst = 1'b1;
      #1;
      nCompared++; if (rf_wen !== 1'b0) begin nMismatched++; $display("[TB] FAIL wb_wen_rst: got %b expected 0", rf_wen); end
      @(negedge clk);
      rst = 1'b0; dec_wen = 1'b0;
      @(negedge clk);
      nCompared++; if ({busy, pc_o, inst_o} !== {1'b0, 64'h8000_0000, NOP}) begin nMismatched++; $display("[TB] FAIL wb_rst_state: got %b/%h/%h expected 0/%h/%h", busy, pc_o, inst_o, 64'h8000_0000, NOP); end
      nCompared++; if (retire_cnt !== 64'd0) begin nMismatched++; $display("[TB] FAIL wb_rst_retire: got %0d expected 0", retire_cnt); end
   endtask

   task automatic test_pc_wrap();
      logic reqF, wenE, wenW;
      logic [63:0] addrF;
      applyReset();
      nCompared++; if (wPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin nMismatched++; $display("[TB] FAIL wrap_rst_pc: got %h expected %h", wPc, 64'hFFFF_FFFF_FFFF_FFFC); end
      applyStart();
      applyStimulus(ADDI, 1'b1, reqF, addrF, wenE, wenW);
      nCompared++; if ({wImemReq, wImemAddr} !== {1'b1, 64'h0}) begin nMismatched++; $display("[TB] FAIL wrap_next_addr: got %b/%h expected 1/%h", wImemReq, wImemAddr, 64'h0); end
   endtask

   initial begin
      test_reset();
      test_idle_ignore();
      test_addi();
      test_store();
      test_back_to_back_halt();
      test_timeout_ok();
      test_timeout_err();
      test_reset_in_wb();
      test_pc_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/exec_seq.md
EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter FETCH_TIMEOUT, default 16, meaning the number of FETCH cycles without imem_rvalid before the error state.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  pulse that begins execution from IDLE.
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  output  64  fetch address (current PC).
REQ-008 SHALL have port imem_rvalid  input  1  fetch data valid.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-010 SHALL have port inst_o  output  32  latched instruction driven to decoder, regfile addresses and immediate extender.
REQ-011 SHALL have port dec_wen  input  1  register write enable from the decoder.
REQ-012 SHALL have port rf_wen  output  1  gated register-file write enable.
REQ-013 SHALL have port pc_o  output  64  current PC.
REQ-014 SHALL have port busy  output  1  high in FETCH, EXEC or WB.
REQ-015 SHALL have port halt  output  1  high in HALT.
REQ-016 SHALL have port err  output  1  high in ERR.
REQ-017 SHALL have port retire_cnt  output  64  count of retired instructions.

Function
REQ-018 SHALL implement states IDLE, FETCH, EXEC, WB, HALT and ERR.
REQ-019 IDLE SHALL go to FETCH on start=1 and ignore start in every other state.
REQ-020 FETCH SHALL drive imem_req=1 and imem_addr=pc, and SHALL latch imem_rdata into inst_o on the cycle imem_rvalid=1.
REQ-021 FETCH with imem_rvalid=1 SHALL go to HALT if imem_rdata==EBREAK (32'h0010_0073), else to EXEC; an EBREAK is not retired.
REQ-022 A FETCH wait counter SHALL clear on FETCH entry and increment each FETCH cycle with imem_rvalid=0.
REQ-023 FETCH SHALL go to ERR when the wait counter reaches FETCH_TIMEOUT-1 with imem_rvalid=0.
REQ-024 imem_rvalid=1 on the timeout cycle SHALL take priority over the timeout.
REQ-025 EXEC SHALL last exactly one cycle with rf_wen=0 to let operands and ALU settle, then go to WB.
REQ-026 WB SHALL drive rf_wen=dec_wen for exactly one cycle, update pc<=pc+4 (modulo 2^64, wrap allowed) and go to FETCH.
REQ-027 rf_wen SHALL be 0 in every state other than WB.
REQ-028 imem_rvalid outside FETCH SHALL be ignored (no latch, no state change).
REQ-029 HALT and ERR SHALL be terminal until rst.
REQ-030 Fetch-to-fetch latency SHALL be 3 cycles with zero-wait memory: FETCH, EXEC, WB.

Reset
REQ-031 rst=1 at any clock edge, including mid-fetch or in WB, SHALL force IDLE, pc=RESET_PC, inst_o=32'h0000_0013 (NOP), wait counter 0 and retire_cnt 0.
REQ-032 During and after reset SHALL hold imem_req, rf_wen, busy, halt and err at 0.
REQ-033 A WB cycle coinciding with rst SHALL not assert rf_wen.

Configuration
REQ-034 With EXEC_SEQ_PERF_EN defined, retire_cnt SHALL increment by 1 on every WB cycle, wrapping at 2^64.
REQ-035 Without EXEC_SEQ_PERF_EN, retire_cnt SHALL be constant 0 and no counter register SHALL exist.

Structure
REQ-036 Package exec_seq_pkg SHALL hold the state enum, the EBREAK_INST and NOP_INST constants, and the PC increment constant (4).
REQ-037 The block SHALL be one module with no sub-module.
REQ-038 The FSM, PC register and counters SHALL stay local to the module.

Verification
REQ-039 Reset, start=1, zero-wait memory returning addi: addr 0x8000_0000, then rf_wen=1 in the 3rd cycle, next addr 0x8000_0004.
REQ-040 Instruction with dec_wen=0 (store-like): rf_wen stays 0 throughout, PC still advances by 4.
REQ-041 imem_rvalid delayed 15 cycles with FETCH_TIMEOUT=16: accepted, no err; delayed beyond: err=1 after 16 FETCH cycles, imem_req=0 afterward.
REQ-042 Memory returns 32'h0010_0073 at PC 0x8000_0008 after two addi: halt=1, pc_o=0x8000_0008, retire_cnt=2 with macro and 0 without.
REQ-043 rst asserted in WB: rf_wen=0 on that edge, then IDLE, pc_o=0x8000_0000, inst_o=0x0000_0013.
REQ-044 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one instruction retired: next imem_addr=0.
